// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared encodings and helpers for the memory port arbiter:
//                FSM state encoding, argument-word offset, counter sizing.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    // Width of the arbiter state register.
    localparam int unsigned c_state_w = 2;

    typedef logic [c_state_w-1:0] state_t;

    // Arbiter states. Encoding is fixed so it can be matched in debug traces.
    localparam state_t c_idle  = 2'b00;
    localparam state_t c_f_opc = 2'b01;
    localparam state_t c_f_arg = 2'b10;
    localparam state_t c_data  = 2'b11;

    // Byte distance from the opcode word to its argument word.
    localparam int unsigned c_arg_offset = 2;

    // Bits needed to hold values 0..max_val inclusive (minimum 1).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/arb_burst_counter.sv
`default_nettype none
// ============================================================================
//  Module      : arb_burst_counter
//  Description : Saturating counter of consecutive data grants made while a
//                fetch is waiting. Synchronous clear has priority over
//                increment; full is raised once the count reaches MAX.
//  Revision    : 1.0 - initial release
// ============================================================================
module arb_burst_counter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX = 4,
    parameter int unsigned CW  = cnt_width(MAX)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic full
);

    logic [CW-1:0] r_count;

    // Count data grants that bypassed a pending fetch, saturating at MAX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count < CW'(MAX))) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Full once the fetch has been bypassed MAX times in a row.
    assign full = (r_count >= CW'(MAX));

endmodule : arb_burst_counter
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one 16-bit memory port between the two-beat
//                instruction fetch (opcode + argument) and the load/store
//                path. Fetch beats are never split by data accesses, a
//                pending fetch is bypassed by at most DATA_BURST data grants,
//                and a PC flush suppresses delivery without cutting a bus
//                cycle short.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW         = 16,
    parameter int unsigned DW         = 16,
    parameter int unsigned DATA_BURST = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    // fetch unit
    input  logic          fetch_req,
    input  logic [AW-1:0] fetch_addr,
    input  logic          fetch_flush,
    output logic [DW-1:0] fetch_opc,
    output logic [DW-1:0] fetch_arg,
    output logic          fetch_valid,
    output logic          hold,
    // load/store path
    input  logic          dat_req,
    input  logic          dat_we,
    input  logic [AW-1:0] dat_addr,
    input  logic [DW-1:0] dat_wdata,
    output logic [DW-1:0] dat_rdata,
    output logic          dat_ack,
    // memory port
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready
);

    state_t        r_state;
    logic [AW-1:0] r_fetch_addr;
    logic          r_flush;

    logic          w_burst_full;
    logic          w_grant_data;
    logic          w_grant_fetch;
    logic          w_burst_inc;
    logic          w_burst_clr;
    logic          w_flush_now;

    // IDLE arbitration: data wins unless a fetch has already been bypassed
    // DATA_BURST times; a granted fetch resets the bypass count.
    always_comb begin
        w_grant_data  = 1'b0;
        w_grant_fetch = 1'b0;
        if (r_state == c_idle) begin
            w_grant_data  = dat_req && (!fetch_req || !w_burst_full);
            w_grant_fetch = fetch_req && !w_grant_data;
        end
        w_burst_inc = w_grant_data && fetch_req;
        w_burst_clr = w_grant_fetch;
        w_flush_now = fetch_flush && ((r_state == c_f_opc) || (r_state == c_f_arg));
    end

    arb_burst_counter #(
        .MAX (DATA_BURST)
    ) u_burst_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_burst_clr),
        .inc   (w_burst_inc),
        .full  (w_burst_full)
    );

    // Port sequencer: state plus all registered memory and handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_idle;
            r_fetch_addr <= '0;
            r_flush      <= 1'b0;
            mem_addr     <= '0;
            mem_rd       <= 1'b0;
            mem_wr       <= 1'b0;
            mem_wdata    <= '0;
            fetch_opc    <= '0;
            fetch_arg    <= '0;
            fetch_valid  <= 1'b0;
            dat_rdata    <= '0;
            dat_ack      <= 1'b0;
        end else begin
            fetch_valid <= 1'b0;
            dat_ack     <= 1'b0;
            case (r_state)
                c_idle: begin
                    r_flush <= 1'b0;
                    if (w_grant_data) begin
                        r_state   <= c_data;
                        mem_addr  <= dat_addr;
                        mem_wdata <= dat_wdata;
                        mem_rd    <= ~dat_we;
                        mem_wr    <= dat_we;
                    end else if (w_grant_fetch) begin
                        r_state      <= c_f_opc;
                        r_fetch_addr <= fetch_addr;
                        mem_addr     <= fetch_addr;
                        mem_rd       <= 1'b1;
                    end
                end
                c_f_opc: begin
                    if (w_flush_now) begin
                        r_flush <= 1'b1;
                    end
                    // Read strobe stays high straight into the argument beat.
                    if (mem_ready) begin
                        fetch_opc <= mem_rdata;
                        mem_addr  <= r_fetch_addr + AW'(c_arg_offset);
                        r_state   <= c_f_arg;
                    end
                end
                c_f_arg: begin
                    if (w_flush_now) begin
                        r_flush <= 1'b1;
                    end
                    if (mem_ready) begin
                        fetch_arg   <= mem_rdata;
                        mem_rd      <= 1'b0;
                        fetch_valid <= ~(r_flush | fetch_flush);
                        r_flush     <= 1'b0;
                        r_state     <= c_idle;
                    end
                end
                c_data: begin
                    if (mem_ready) begin
                        dat_ack <= 1'b1;
                        if (!mem_wr) begin
                            dat_rdata <= mem_rdata;
                        end
                        mem_rd  <= 1'b0;
                        mem_wr  <= 1'b0;
                        r_state <= c_idle;
                    end
                end
                default: begin
                    r_state <= c_idle;
                    mem_rd  <= 1'b0;
                    mem_wr  <= 1'b0;
                end
            endcase
        end
    end

    // Stall while the port is busy or a fetch is outstanding; the fetch
    // unit is released in the cycle its words are delivered.
    assign hold = (r_state != c_idle) | (fetch_req & ~fetch_valid);

    // A data requester must hold its request for the whole access.
    a_dat_req_held : assert property (
        @(posedge clk) disable iff (!rst_n) (r_state == c_data) |-> dat_req
    );

    // Fetch delivery and data acknowledge are mutually exclusive.
    a_no_dual_pulse : assert property (
        @(posedge clk) disable iff (!rst_n) !(fetch_valid && dat_ack)
    );

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Directed self-checking bench for mem_port_arbiter with a
//                behavioural memory (programmable wait states).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fetch_req = 1'b0;
    logic [AW-1:0] fetch_addr = '0;
    logic          fetch_flush = 1'b0;
    logic [DW-1:0] fetch_opc;
    logic [DW-1:0] fetch_arg;
    logic          fetch_valid;
    logic          hold;
    logic          dat_req = 1'b0;
    logic          dat_we = 1'b0;
    logic [AW-1:0] dat_addr = '0;
    logic [DW-1:0] dat_wdata = '0;
    logic [DW-1:0] dat_rdata;
    logic          dat_ack;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic          mem_wr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .AW         (AW),
        .DW         (DW),
        .DATA_BURST (4)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_flush (fetch_flush),
        .fetch_opc   (fetch_opc),
        .fetch_arg   (fetch_arg),
        .fetch_valid (fetch_valid),
        .hold        (hold),
        .dat_req     (dat_req),
        .dat_we      (dat_we),
        .dat_addr    (dat_addr),
        .dat_wdata   (dat_wdata),
        .dat_rdata   (dat_rdata),
        .dat_ack     (dat_ack),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready)
    );

    // Memory: ready after wait_n stalled cycles of an active strobe.
    int wait_n = 0;
    int wcnt   = 0;
    always @(posedge clk) begin
        if (!(mem_rd | mem_wr) || mem_ready) wcnt <= 0;
        else                                 wcnt <= wcnt + 1;
    end
    assign mem_ready = (mem_rd | mem_wr) && (wcnt >= wait_n);

    // Fixed contents for the directed addresses, address^0x5A5A elsewhere.
    always_comb begin
        case (mem_addr)
            16'h0100: mem_rdata = 16'hA955;
            16'h0102: mem_rdata = 16'h1234;
            16'h2000: mem_rdata = 16'hBEEF;
            default:  mem_rdata = mem_addr ^ 16'h5A5A;
        endcase
    end

    // Pulse counters and log of completed bus cycles.
    int fv_cnt = 0;
    int ack_cnt = 0;
    int dual_cnt = 0;
    logic [AW-1:0] cmpl_q[$];
    always @(posedge clk) begin
        if (fetch_valid)            fv_cnt   <= fv_cnt + 1;
        if (dat_ack)                ack_cnt  <= ack_cnt + 1;
        if (fetch_valid && dat_ack) dual_cnt <= dual_cnt + 1;
        if (mem_ready && rst_n)     cmpl_q.push_back(mem_addr);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int n_grants();
        int n = 0;
        foreach (cmpl_q[i]) if (cmpl_q[i] != 16'h0302) n++;
        return n;
    endfunction

    int f0, a0, q0, lat, rd_cyc, cyc, k;
    logic [9:0] seq;

    initial begin
        // ---------------- reset state ----------------
        @(negedge clk);
        check("rst_mem_rd", mem_rd, 0);
        check("rst_mem_wr", mem_wr, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_fetch_valid", fetch_valid, 0);
        check("rst_dat_ack", dat_ack, 0);
        check("rst_hold", hold, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // ---------------- 1: fetch only ----------------
        wait_n = 0;
        fetch_addr = 16'h0100; fetch_req = 1'b1;
        @(negedge clk);
        check("t1_rd_opc", mem_rd, 1);
        check("t1_addr_opc", mem_addr, 16'h0100);
        check("t1_hold_busy", hold, 1);
        fetch_req = 1'b0;
        @(negedge clk);
        check("t1_rd_arg", mem_rd, 1);
        check("t1_addr_arg", mem_addr, 16'h0102);
        check("t1_valid_early", fetch_valid, 0);
        @(negedge clk);
        check("t1_valid", fetch_valid, 1);
        check("t1_opc", fetch_opc, 16'hA955);
        check("t1_arg", fetch_arg, 16'h1234);
        check("t1_hold_low", hold, 0);
        check("t1_rd_low", mem_rd, 0);
        @(negedge clk);
        check("t1_valid_pulse", fetch_valid, 0);

        // ---------------- 2: load with 2 wait cycles ----------------
        wait_n = 2;
        dat_addr = 16'h2000; dat_we = 1'b0; dat_req = 1'b1;
        a0 = ack_cnt; lat = 0; rd_cyc = 0;
        while (dat_ack !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
            if (mem_rd) rd_cyc++;
        end
        dat_req = 1'b0;
        check("t2_latency", lat, 4);
        check("t2_rd_cycles", rd_cyc, 3);
        check("t2_rdata", dat_rdata, 16'hBEEF);
        repeat (3) @(negedge clk);
        check("t2_ack_once", ack_cnt - a0, 1);

        // ---------------- 3: continuous contention ----------------
        wait_n = 0;
        cmpl_q.delete();
        f0 = fv_cnt; a0 = ack_cnt;
        fetch_addr = 16'h0300; dat_addr = 16'h5000; dat_we = 1'b0;
        fetch_req = 1'b1; dat_req = 1'b1;
        cyc = 0;
        while (n_grants() < 10 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        fetch_req = 1'b0; dat_req = 1'b0;
        repeat (4) @(negedge clk);
        seq = '0; k = 0;
        foreach (cmpl_q[i]) begin
            if (cmpl_q[i] != 16'h0302 && k < 10) begin
                seq[k] = (cmpl_q[i] == 16'h0300);
                k++;
            end
        end
        check("t3_grant_order", seq, 10'h210);
        check("t3_fetches", fv_cnt - f0, 2);
        check("t3_acks", ack_cnt - a0, 8);

        // ---------------- 4: data request during fetch ----------------
        fetch_addr = 16'h0600; fetch_req = 1'b1;
        @(negedge clk);
        check("t4_opc_addr", mem_addr, 16'h0600);
        fetch_req = 1'b0;
        dat_addr = 16'h7000; dat_we = 1'b1; dat_wdata = 16'h55AA; dat_req = 1'b1;
        @(negedge clk);
        check("t4_arg_addr", mem_addr, 16'h0602);
        check("t4_no_wr_in_fetch", mem_wr, 0);
        @(negedge clk);
        check("t4_valid", fetch_valid, 1);
        check("t4_no_ack_yet", dat_ack, 0);
        check("t4_wr_after_valid", mem_wr, 0);
        @(negedge clk);
        check("t4_wr", mem_wr, 1);
        check("t4_wr_addr", mem_addr, 16'h7000);
        check("t4_wdata", mem_wdata, 16'h55AA);
        @(negedge clk);
        check("t4_ack", dat_ack, 1);
        check("t4_rdata_kept", dat_rdata, 16'h0A5A);
        dat_req = 1'b0;
        @(negedge clk);

        // ---------------- 5: flush in F_ARG ----------------
        f0 = fv_cnt; q0 = cmpl_q.size();
        fetch_addr = 16'h0800; fetch_req = 1'b1;
        @(negedge clk);
        fetch_req = 1'b0;
        @(negedge clk);
        check("t5_in_arg", mem_addr, 16'h0802);
        fetch_flush = 1'b1;
        @(negedge clk);
        fetch_flush = 1'b0;
        check("t5_no_valid", fetch_valid, 0);
        repeat (3) @(negedge clk);
        check("t5_both_reads", cmpl_q.size() - q0, 2);
        check("t5_valid_count", fv_cnt - f0, 0);
        // flush raised in IDLE alongside the new request is ignored
        fetch_addr = 16'h0400; fetch_req = 1'b1; fetch_flush = 1'b1;
        @(negedge clk);
        fetch_req = 1'b0; fetch_flush = 1'b0;
        check("t5_refetch_addr", mem_addr, 16'h0400);
        @(negedge clk);
        @(negedge clk);
        check("t5_refetch_valid", fetch_valid, 1);
        check("t5_refetch_opc", fetch_opc, 16'h5E5A);
        check("t5_refetch_arg", fetch_arg, 16'h5E58);

        // ---------------- 6: reset mid-store, then wrap ----------------
        @(negedge clk);
        wait_n = 5; a0 = ack_cnt;
        dat_addr = 16'h9000; dat_we = 1'b1; dat_wdata = 16'h1111; dat_req = 1'b1;
        @(negedge clk);
        check("t6_wr_active", mem_wr, 1);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("t6_rst_wr", mem_wr, 0);
        check("t6_rst_addr", mem_addr, 0);
        check("t6_rst_wdata", mem_wdata, 0);
        check("t6_rst_rdata", dat_rdata, 0);
        check("t6_rst_opc", fetch_opc, 0);
        check("t6_rst_arg", fetch_arg, 0);
        dat_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_no_ack", ack_cnt - a0, 0);
        wait_n = 0;
        fetch_addr = 16'hFFFE; fetch_req = 1'b1;
        @(negedge clk);
        fetch_req = 1'b0;
        check("t6_wrap_opc_addr", mem_addr, 16'hFFFE);
        @(negedge clk);
        check("t6_wrap_arg_addr", mem_addr, 16'h0000);
        @(negedge clk);
        check("t6_wrap_valid", fetch_valid, 1);
        check("t6_wrap_opc", fetch_opc, 16'hA5A4);
        check("t6_wrap_arg", fetch_arg, 16'h5A5A);

        @(negedge clk);
        check("no_dual_pulse", dual_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_mem_port_arbiter
`default_nettype wire
